// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and helpers for the two-port unified-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

    // Arbiter sequence states; encodings are fixed so waveforms and
    // external monitors decode them the same way.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Owner encodings, which are also the value driven onto mem_sel.
    localparam logic OWN_IF = 1'b0;   // port 0, instruction fetch
    localparam logic OWN_DM = 1'b1;   // port 1, data load/store

    // Round-robin pick between the two ports. A lone requester always
    // wins. On a tie the port that did not win last time gets the memory.
    function automatic logic rr_pick(input logic p0_req,
                                     input logic p1_req,
                                     input logic prev_winner);
        logic pick;
        pick = OWN_IF;
        if (p0_req && p1_req) begin
            pick = ~prev_winner;
        end else if (p1_req) begin
            pick = OWN_DM;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_nmux.sv
// N-bit 2:1 steering mux for address and write data into the memory.
// Latency: combinational, zero cycles.
// Backpressure: none; the select comes from a register owned by the arbiter.
module mem_port_arbiter_nmux #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_sel,
    output logic [N-1:0] o_y
);

    // sel=0 passes port 0 (A), sel=1 passes port 1 (B).
    assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch (port 0) and data (port 1).
// Latency: grant decided in IDLE, LAT cycles of BUSY, one DONE cycle (LAT+2 per access).
// Backpressure: level-held req waits through BUSY/DONE; accesses are never interrupted.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic          mem_sel,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata
);

    // Counter reload value: BUSY lasts cnt+1 cycles, so LAT-1 gives LAT cycles.
    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    state_t        r_state;
    logic          r_owner;
    logic          r_last;
    logic [3:0]    r_cnt;
    logic [DW-1:0] r_rdata;

    state_t        w_state_nxt;
    logic          w_owner_nxt;
    logic          w_last_nxt;
    logic [3:0]    w_cnt_nxt;
    logic [DW-1:0] w_rdata_nxt;

    logic          w_mem_en;
    logic          w_mem_we;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_done0;
    logic          w_done1;

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_owner <= OWN_IF;
            r_last  <= OWN_DM;   // so port 0 wins the very first tie
            r_cnt   <= 4'd0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rdata <= w_rdata_nxt;
        end
    end

    // Next-state and output decode for the IDLE -> BUSY -> DONE sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_rdata_nxt = r_rdata;
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_done0     = 1'b0;
        w_done1     = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Owner (and therefore mem_sel) only changes here, so the
                // steering muxes are stable for the whole access.
                if (req0 || req1) begin
                    w_owner_nxt = rr_pick(req0, req1, r_last);
                    w_cnt_nxt   = LAT_M1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                w_mem_en = 1'b1;
                w_mem_we = (r_owner == OWN_DM) ? we1 : we0;
                w_gnt0   = (r_owner == OWN_IF);
                w_gnt1   = (r_owner == OWN_DM);
                if (r_cnt == 4'd0) begin
                    // Read data is valid in the last BUSY cycle; on writes
                    // this captures a don't-care value.
                    w_rdata_nxt = mem_rdata;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_DONE: begin
                w_gnt0      = (r_owner == OWN_IF);
                w_gnt1      = (r_owner == OWN_DM);
                w_done0     = (r_owner == OWN_IF);
                w_done1     = (r_owner == OWN_DM);
                w_last_nxt  = r_owner;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign mem_en  = w_mem_en;
    assign mem_we  = w_mem_we;
    assign mem_sel = r_owner;
    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign done0   = w_done0;
    assign done1   = w_done1;
    assign rdata   = r_rdata;

    mem_port_arbiter_nmux #(.N(AW)) u_addr_mux (
        .i_a   (addr0),
        .i_b   (addr1),
        .i_sel (r_owner),
        .o_y   (mem_addr)
    );

    mem_port_arbiter_nmux #(.N(DW)) u_wdata_mux (
        .i_a   (wdata0),
        .i_b   (wdata1),
        .i_sel (r_owner),
        .o_y   (mem_wdata)
    );

endmodule
